// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_pkg
// Description : binary32 field constants and the operand class type.
// Revision    : 1.0
// ============================================================================
package fp_pkg;

  typedef enum logic [2:0] {
    ZERO    = 3'd0,
    SUBNORM = 3'd1,
    NORMAL  = 3'd2,
    INF     = 3'd3,
    QNAN    = 3'd4,
    SNAN    = 3'd5
  } fp_class_t;

  localparam int          EXP_MSB   = 30;
  localparam int          EXP_LSB   = 23;
  localparam int          FRAC_W    = 23;
  localparam logic [7:0]  EXP_ALL1  = 8'hFF;
  localparam logic [31:0] CANON_NAN = 32'h7FC00000;

  // Product is fixed by the class alone (NaN, inf or zero result).
  function automatic logic is_special_class(input fp_class_t c);
    return (c == ZERO) || (c == INF) || (c == QNAN) || (c == SNAN);
  endfunction

endpackage : fp_pkg
`default_nettype wire

// File: rtl/fp_mul_operand_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_operand_queue_if
// Description : Producer/consumer bundle of the multiplier operand queue.
// Revision    : 1.0
// ============================================================================
interface fp_mul_operand_queue_if #(
  parameter int DEPTH = 4
);
  import fp_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_a;
  logic [31:0]     in_b;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_a;
  logic [31:0]     out_b;
  fp_class_t       out_a_class;
  fp_class_t       out_b_class;
  logic            out_special;
  logic [PTR_W:0]  level;
  logic            flag_invalid;
  logic            flag_snan;
  logic            flag_clr;

  modport slave (
    input  in_valid, in_a, in_b, out_ready, flag_clr,
    output in_ready, out_valid, out_a, out_b, out_a_class, out_b_class,
           out_special, level, flag_invalid, flag_snan
  );

  modport master (
    output in_valid, in_a, in_b, out_ready, flag_clr,
    input  in_ready, out_valid, out_a, out_b, out_a_class, out_b_class,
           out_special, level, flag_invalid, flag_snan
  );

endinterface : fp_mul_operand_queue_if
`default_nettype wire

// File: rtl/fp_classify.sv
`default_nettype none
// ============================================================================
// Module      : fp_classify
// Description : Combinational IEEE-754 binary32 operand classifier.
// Revision    : 1.0
// ============================================================================
module fp_classify
  import fp_pkg::*;
(
  input  wire logic [31:0] i_data,
  output fp_class_t        o_class
);

  logic [7:0]        w_exp;
  logic [FRAC_W-1:0] w_frac;
  logic              w_unused_sign;

  assign w_exp         = i_data[EXP_MSB:EXP_LSB];
  assign w_frac        = i_data[FRAC_W-1:0];
  assign w_unused_sign = i_data[31];

  // Quiet/signalling is decided by the top fraction bit once exp is all ones.
  always_comb begin
    o_class = NORMAL;
    if (w_exp == 8'd0) begin
      o_class = (w_frac == '0) ? ZERO : SUBNORM;
    end else if (w_exp == EXP_ALL1) begin
      if (w_frac == '0)             o_class = INF;
      else if (w_frac[FRAC_W-1])    o_class = QNAN;
      else                          o_class = SNAN;
    end
  end

endmodule : fp_classify
`default_nettype wire

// File: rtl/fp_mul_operand_queue.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_operand_queue
// Description : Show-ahead operand FIFO with per-operand class and sticky flags.
// Revision    : 1.0
// ============================================================================
module fp_mul_operand_queue
  import fp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  fp_mul_operand_queue_if.slave   q
);

  localparam int             PTR_W  = $clog2(DEPTH);
  localparam logic [PTR_W:0] c_FULL = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_level;
  logic             r_flag_invalid;
  logic             r_flag_snan;

  logic [31:0]      r_mem_a  [DEPTH];
  logic [31:0]      r_mem_b  [DEPTH];
  fp_class_t        r_mem_ac [DEPTH];
  fp_class_t        r_mem_bc [DEPTH];

  fp_class_t        w_a_class;
  fp_class_t        w_b_class;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;
  logic             w_a_nan;
  logic             w_b_nan;
  logic             w_inf_zero;
  logic             w_set_invalid;
  logic             w_set_snan;

  fp_classify u_cls_a (.i_data(q.in_a), .o_class(w_a_class));
  fp_classify u_cls_b (.i_data(q.in_b), .o_class(w_b_class));

  // in_ready depends on registered level only; a full queue stalls one cycle.
  assign w_in_ready  = (r_level != c_FULL);
  assign w_out_valid = (r_level != '0);
  assign w_push      = q.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && q.out_ready;

  assign w_a_nan       = (w_a_class == QNAN) || (w_a_class == SNAN);
  assign w_b_nan       = (w_b_class == QNAN) || (w_b_class == SNAN);
  assign w_inf_zero    = ((w_a_class == INF) && (w_b_class == ZERO)) ||
                         ((w_a_class == ZERO) && (w_b_class == INF));
  assign w_set_invalid = w_push && (w_a_nan || w_b_nan || w_inf_zero);
  assign w_set_snan    = w_push && ((w_a_class == SNAN) || (w_b_class == SNAN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_level        <= '0;
      r_flag_invalid <= 1'b0;
      r_flag_snan    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase

      // A set condition in the same cycle as a clear takes priority.
      if (w_set_invalid)   r_flag_invalid <= 1'b1;
      else if (q.flag_clr) r_flag_invalid <= 1'b0;

      if (w_set_snan)      r_flag_snan <= 1'b1;
      else if (q.flag_clr) r_flag_snan <= 1'b0;
    end
  end

  // Storage carries no reset; only the control state defines validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr]  <= q.in_a;
      r_mem_b[r_wr_ptr]  <= q.in_b;
      r_mem_ac[r_wr_ptr] <= w_a_class;
      r_mem_bc[r_wr_ptr] <= w_b_class;
    end
  end

  assign q.in_ready     = w_in_ready;
  assign q.out_valid    = w_out_valid;
  assign q.out_a        = r_mem_a[r_rd_ptr];
  assign q.out_b        = r_mem_b[r_rd_ptr];
  assign q.out_a_class  = r_mem_ac[r_rd_ptr];
  assign q.out_b_class  = r_mem_bc[r_rd_ptr];
  assign q.out_special  = is_special_class(r_mem_ac[r_rd_ptr]) ||
                          is_special_class(r_mem_bc[r_rd_ptr]);
  assign q.level        = r_level;
  assign q.flag_invalid = r_flag_invalid;
  assign q.flag_snan    = r_flag_snan;

endmodule : fp_mul_operand_queue
`default_nettype wire

// File: tb/tb_fp_mul_operand_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_mul_operand_queue
// Description : Directed plus randomized bench against a queue-based model.
// Revision    : 1.0
// ============================================================================
module tb_fp_mul_operand_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } pair_t;

  logic clk;
  logic rst_n;
  fp_mul_operand_queue_if #(.DEPTH(DEPTH)) q ();

  fp_mul_operand_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pair_t mq[$];
  logic  m_inv;
  logic  m_snan;
  int    n_pass;
  int    n_total;

  // Class codes: 0 zero, 1 subnormal, 2 normal, 3 inf, 4 qnan, 5 snan.
  function automatic logic [2:0] ref_class(input logic [31:0] v);
    int unsigned e;
    int unsigned f;
    e = v[30:23];
    f = v[22:0];
    if (e == 0)   return (f == 0) ? 3'd0 : 3'd1;
    if (e != 255) return 3'd2;
    if (f == 0)   return 3'd3;
    return (f >= 32'h400000) ? 3'd4 : 3'd5;
  endfunction

  function automatic logic [31:0] rnd_op();
    logic        s;
    logic [22:0] f;
    s = 1'($urandom);
    f = 23'($urandom);
    case ($urandom_range(0, 7))
      0:       return {s, 31'd0};
      1:       return {s, 8'd0, (f == 0) ? 23'd1 : f};
      2:       return {s, 8'hFF, 23'd0};
      3:       return {s, 8'hFF, 1'b1, f[21:0]};
      4:       return {s, 8'hFF, 1'b0, (f[21:0] == 0) ? 22'd5 : f[21:0]};
      default: return {s, 8'($urandom_range(1, 254)), f};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_state(input string tag);
    logic [2:0] ca;
    logic [2:0] cb;
    chk({tag, ".out_valid"}, 32'(q.out_valid), 32'(mq.size() != 0));
    chk({tag, ".level"}, 32'(q.level), 32'(mq.size()));
    chk({tag, ".in_ready"}, 32'(q.in_ready), 32'(mq.size() != DEPTH));
    chk({tag, ".flag_invalid"}, 32'(q.flag_invalid), 32'(m_inv));
    chk({tag, ".flag_snan"}, 32'(q.flag_snan), 32'(m_snan));
    if (mq.size() != 0) begin
      ca = ref_class(mq[0].a);
      cb = ref_class(mq[0].b);
      chk({tag, ".out_a"}, q.out_a, mq[0].a);
      chk({tag, ".out_b"}, q.out_b, mq[0].b);
      chk({tag, ".a_class"}, 32'(q.out_a_class), 32'(ca));
      chk({tag, ".b_class"}, 32'(q.out_b_class), 32'(cb));
      chk({tag, ".special"}, 32'(q.out_special),
          32'((ca != 3'd1 && ca != 3'd2) || (cb != 3'd1 && cb != 3'd2)));
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check at negedge.
  task automatic step(input string tag, input logic v, input logic [31:0] a,
                      input logic [31:0] b, input logic rdy, input logic clr);
    logic push;
    logic pop;
    logic [2:0] ca;
    logic [2:0] cb;
    pair_t p;
    q.in_valid  = v;
    q.in_a      = a;
    q.in_b      = b;
    q.out_ready = rdy;
    q.flag_clr  = clr;
    push = v && (mq.size() != DEPTH);
    pop  = rdy && (mq.size() != 0);
    @(posedge clk);
    ca = ref_class(a);
    cb = ref_class(b);
    if (pop) void'(mq.pop_front());
    if (push) begin
      p.a = a;
      p.b = b;
      mq.push_back(p);
    end
    if (push && (ca >= 3'd4 || cb >= 3'd4 || (ca == 3'd3 && cb == 3'd0) ||
                 (ca == 3'd0 && cb == 3'd3))) m_inv = 1'b1;
    else if (clr) m_inv = 1'b0;
    if (push && (ca == 3'd5 || cb == 3'd5)) m_snan = 1'b1;
    else if (clr) m_snan = 1'b0;
    @(negedge clk);
    check_state(tag);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    m_inv   = 1'b0;
    m_snan  = 1'b0;
    rst_n   = 1'b0;
    q.in_valid  = 1'b0;
    q.in_a      = '0;
    q.in_b      = '0;
    q.out_ready = 1'b0;
    q.flag_clr  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_state("reset");

    step("first", 1'b1, 32'h3F800000, 32'h40000000, 1'b0, 1'b0);
    while (mq.size() != 0) step("drain0", 1'b0, '0, '0, 1'b1, 1'b0);

    // Five offers into a four-deep queue; the fifth is refused.
    for (int i = 0; i < 5; i++)
      step("fill", 1'b1, 32'h3F800000 + 32'(i), 32'h40400000 + 32'(i), 1'b0, 1'b0);
    step("pop1", 1'b0, '0, '0, 1'b1, 1'b0);
    while (mq.size() != 0) step("drain1", 1'b0, '0, '0, 1'b1, 1'b0);

    step("lvl2a", 1'b1, 32'h41000000, 32'h41100000, 1'b0, 1'b0);
    step("lvl2b", 1'b1, 32'h41200000, 32'h41300000, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      step("stream", 1'b1, 32'h42000000 + 32'(i << 16), 32'hC2000000 + 32'(i), 1'b1, 1'b0);
    while (mq.size() != 0) step("drain2", 1'b0, '0, '0, 1'b1, 1'b0);

    for (int i = 0; i < 300; i++)
      step("rand", ($urandom_range(0, 3) != 0), rnd_op(), rnd_op(),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
    while (mq.size() != 0) step("drain3", 1'b0, '0, '0, 1'b1, 1'b0);
    step("clr0", 1'b0, '0, '0, 1'b0, 1'b1);

    step("infzero", 1'b1, 32'h7F800000, 32'h00000000, 1'b0, 1'b0);
    step("snan_clr", 1'b1, 32'h7F800001, 32'h00000001, 1'b1, 1'b1);
    step("clr_only", 1'b0, '0, '0, 1'b0, 1'b1);

    step("pre_rst1", 1'b1, 32'h7FC00000, 32'h3F800000, 1'b0, 1'b0);
    step("pre_rst2", 1'b1, 32'h40000000, 32'h40800000, 1'b0, 1'b0);
    // Reset lands mid-cycle; outputs must clear before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("async.out_valid", 32'(q.out_valid), 32'd0);
    chk("async.level", 32'(q.level), 32'd0);
    chk("async.flag_invalid", 32'(q.flag_invalid), 32'd0);
    chk("async.flag_snan", 32'(q.flag_snan), 32'd0);
    chk("async.in_ready", 32'(q.in_ready), 32'd1);
    mq.delete();
    m_inv  = 1'b0;
    m_snan = 1'b0;
    q.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_state("post_rst");
    step("post_push", 1'b1, 32'hBF800000, 32'h00400000, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_fp_mul_operand_queue
`default_nettype wire

// File: doc/fp_mul_operand_queue.md
Name: fp_mul_operand_queue

Overview:
- Operand-issue stage directly upstream of the combinational single-precision multiplier.
- Buffers operand pairs from a valid/ready producer in a DEPTH-entry FIFO.
- Classifies each IEEE-754 binary32 operand at enqueue and stores the class with the entry.
- Presents the head pair, with its classes, to the multiplier stage and maintains sticky exception flags for accepted pairs.

Parameters:
- DEPTH, 4, number of FIFO entries. Must be a power of two and at least 2.
- PTR_W, $clog2(DEPTH), width of the read/write pointers. Derived; never overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer has an operand pair.
- in_ready  out  1  queue can accept a pair.
- in_a  in  32  operand A, binary32.
- in_b  in  32  operand B, binary32.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  multiplier stage consumes the head.
- out_a  out  32  head operand A.
- out_b  out  32  head operand B.
- out_a_class  out  3  class of out_a.
- out_b_class  out  3  class of out_b.
- out_special  out  1  head product is fully determined by the classes: NaN, inf or zero.
- level  out  PTR_W+1  current occupancy, 0..DEPTH.
- flag_invalid  out  1  sticky: an accepted pair had a NaN operand, or inf×zero.
- flag_snan  out  1  sticky: an accepted pair had a signalling NaN.
- flag_clr  in  1  synchronous clear of both sticky flags.

Behaviour:
- Classification per operand, exp = bits[30:23], frac = bits[22:0]:
  - ZERO: exp 0, frac 0.
  - SUBNORM: exp 0, frac nonzero.
  - NORMAL: exp 1..254.
  - INF: exp 255, frac 0.
  - QNAN: exp 255, frac[22] = 1.
  - SNAN: exp 255, frac[22] = 0, frac nonzero.
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- in_ready = (level != DEPTH). It is a pure function of registered state, with no same-cycle pop pass-through; a full queue stalls for one cycle even if a pop occurs.
- out_valid = (level != 0).
- out_a, out_b and both classes are show-ahead from the entry at rd_ptr. They are driven combinationally from storage and are held stable while out_valid && !out_ready.
- Latency: a pair pushed into an empty queue appears on the outputs the next cycle.
- Simultaneous push and pop at any non-full level: level is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. level is a separate counter, not derived from the pointers.
- Push while full is impossible by construction. Pop while empty is ignored.
- out_special = either class is ZERO, INF, QNAN or SNAN.
- Sticky flags, evaluated on push only:
  - flag_invalid is set if either class is QNAN or SNAN, or if one class is INF and the other is ZERO.
  - flag_snan is set if either class is SNAN.
  - If flag_clr and a set condition occur in the same cycle, the set wins and the flag reads 1 next cycle.
- Reset (async assert, sync release): level, rd_ptr, wr_ptr and both flags go to 0. Therefore in_ready = 1 and out_valid = 0. Storage is not reset.
- Reset asserted mid-operation discards all entries.
- out_a, out_b and the class outputs are don't-care while out_valid = 0.

Decomposition:
- Shared package fp_pkg holds:
  - typedef fp_class_t (3 bits) with ZERO = 0, SUBNORM = 1, NORMAL = 2, INF = 3, QNAN = 4, SNAN = 5.
  - Field constants EXP_MSB = 30, EXP_LSB = 23, FRAC_W = 23, EXP_ALL1 = 8'hFF, CANON_NAN = 32'h7FC00000.
- One sub-module, fp_classify: combinational, 32-bit in, fp_class_t out. Instantiated twice at the FIFO write side.
- FIFO storage and control stay inline.

Test Plan:
- Reset, then push (3F800000, 40000000), with out_ready = 0 → next cycle out_valid = 1, out_a = 3F800000, out_b = 40000000, both classes NORMAL, out_special = 0, level = 1.
- Push 5 pairs back-to-back with out_ready = 0 → in_ready falls after the 4th push and level = 4. Then pulse out_ready for 1 cycle → level = 3 and in_ready = 1 the following cycle. FIFO order is preserved across pointer wrap.
- Continuous push and pop with level = 2 for 10 cycles → level stays 2 and outputs follow the input order with 2-deep delay.
- Push (7F800000, 00000000) → classes INF/ZERO, out_special = 1, flag_invalid = 1, flag_snan = 0.
- Push (7F800001, 00000001) in the same cycle as flag_clr = 1 → classes SNAN/SUBNORM; flag_invalid and flag_snan both read 1 (set wins). A later flag_clr alone clears both.
- Assert rst_n = 0 while level = 3 → out_valid = 0, level = 0 and flags = 0 immediately, without waiting for a clock edge.
